led_scan_display: RTL and testbench



---
 rtl/led_scan_display_pkg.sv | 19 +
 rtl/led_scan_display_if.sv | 13 +
 rtl/led_seg_decode.sv | 11 +
 rtl/led_scan_display.sv | 159 +++++++++++++++
 tb/tb_led_scan_display.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_scan_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
// Segment patterns are active-high with a = bit 0, g = bit 6; the dp bit is
// added by the decoder as bit 7.
package led_pkg;

    typedef struct packed {
        logic       dp;
        logic [3:0] val;
    } digit_code_t;

    // Active-high "nothing lit" pattern; polarity is applied at the output register.
    localparam logic [7:0] SEG_OFF = 8'h00;

    localparam logic [6:0] SEG_PATTERN [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/led_scan_display_if.sv
// Register-side bus of the display driver: the write strobe with its data and
// blank mask, plus the "shadow not yet shown" status flag.
interface led_scan_display_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [5*DIGITS-1:0]   digit_data;
    logic [DIGITS-1:0]     blank_mask;
    logic                  o_pending;

    modport master (output load, digit_data, blank_mask, input o_pending);
    modport slave  (input load, digit_data, blank_mask, output o_pending);
endinterface

// File: rtl/led_seg_decode.sv
// Combinational hex + dp to 7-segment decoder, active-high output {dp,g..a}.
module led_seg_decode
    import led_pkg::*;
(
    input  digit_code_t code,
    output logic [7:0]  seg
);

    assign seg = {code.dp, SEG_PATTERN[code.val]};

endmodule

// File: rtl/led_scan_display.sv
// Multiplexed 7-segment display driver with double-buffered digit data and a
// per-slot dead time to suppress ghosting. All outputs are registered and lag
// the scan counters by one cycle.
// Optional feature: define LED_SCAN_ZERO_SUPPRESS_EN to darken leading zero
// digits (nibble 0 and dp 0, with all more-significant digits also dark).
module led_scan_display
    import led_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 50000,
    parameter int DEAD_CYC   = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst,
    led_scan_display_if.slave   bus,
    output logic [7:0]          o_seg,
    output logic [DIGITS-1:0]   o_dig_sel,
    output logic                o_frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] LAST_DIV = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYC);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [7:0]        SEG_IDLE = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_IDLE = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]          div_cnt;
    logic [IW-1:0]          idx;
    logic                   boundary;

    logic [5*DIGITS-1:0]    shadow_data;
    logic [DIGITS-1:0]      shadow_mask;
    logic [5*DIGITS-1:0]    active_data;
    logic [DIGITS-1:0]      active_mask;
    logic                   pending_reg;

    digit_code_t            codes [DIGITS];
    logic [DIGITS-1:0]      zero_dark;
    digit_code_t            cur_code;
    logic [7:0]             cur_seg;
    logic                   cur_dark;
    logic [7:0]             seg_next;
    logic [DIGITS-1:0]      sel_next;

    // The last cycle of the last slot closes the frame; active data swaps here.
    assign boundary = (div_cnt == LAST_DIV) && (idx == LAST_IDX);

    // Prescaler and slot index; idx stays 0 when only one digit exists.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == LAST_DIV) begin
            div_cnt <= '0;
            idx     <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Double buffer: writes land in the shadow and are promoted only at a
    // frame boundary, so a frame never mixes old and new digits. A write on
    // the boundary cycle bypasses the shadow and leaves nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_data <= '0;
            shadow_mask <= '0;
            active_data <= '0;
            active_mask <= '0;
            pending_reg <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_data <= bus.digit_data;
                shadow_mask <= bus.blank_mask;
            end
            if (boundary && bus.load) begin
                active_data <= bus.digit_data;
                active_mask <= bus.blank_mask;
                pending_reg <= 1'b0;
            end else if (boundary && pending_reg) begin
                active_data <= shadow_data;
                active_mask <= shadow_mask;
                pending_reg <= 1'b0;
            end else if (bus.load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.o_pending = pending_reg;

    // Split the packed active register into per-digit codes.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_codes
            assign codes[gi] = active_data[5*gi +: 5];
        end
    endgenerate

`ifdef LED_SCAN_ZERO_SUPPRESS_EN
    logic zero_run;

    // Walk from the most-significant digit down; a run of blank zeros stops at
    // the first nonzero code, and digit 0 is always shown.
    always_comb begin
        zero_dark = '0;
        zero_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run && ({codes[i].dp, codes[i].val} == 5'd0);
            zero_dark[i] = zero_run;
        end
    end
`else
    assign zero_dark = '0;
`endif

    assign cur_code = codes[idx];
    assign cur_dark = active_mask[idx] | zero_dark[idx];

    led_seg_decode u_seg_decode (
        .code (cur_code),
        .seg  (cur_seg)
    );

    // Slot content before polarity: dark during dead time, else the selected digit.
    always_comb begin
        seg_next = SEG_OFF;
        sel_next = '0;
        if (div_cnt >= DEAD_LIM) begin
            sel_next[idx] = 1'b1;
            if (!cur_dark) begin
                seg_next = cur_seg;
            end
        end
    end

    // Output registers; polarity inversion happens here so pins are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg         <= SEG_IDLE;
            o_dig_sel     <= SEL_IDLE;
            o_frame_start <= 1'b0;
        end else begin
            if (ACTIVE_LOW != 0) begin
                o_seg     <= ~seg_next;
                o_dig_sel <= ~sel_next;
            end else begin
                o_seg     <= seg_next;
                o_dig_sel <= sel_next;
            end
            o_frame_start <= (div_cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_led_scan_display.sv
// Directed testbench for led_scan_display: 4 digits, 8-cycle slots, 2-cycle
// dead time, active-low outputs. Each test starts and ends on the sample
// cycle where o_frame_start is high (slot 0, dead cycle 0 on the outputs).
module tb_led_scan_display;

    localparam int DIGITS = 4;

`ifdef LED_SCAN_ZERO_SUPPRESS_EN
    localparam logic [7:0] ZERO_MS_SEG = 8'hFF;
`else
    localparam logic [7:0] ZERO_MS_SEG = 8'hC0;
`endif

    logic              clk;
    logic              rst;
    logic [7:0]        o_seg;
    logic [DIGITS-1:0] o_dig_sel;
    logic              o_frame_start;

    int compared   = 0;
    int mismatched = 0;

    led_scan_display_if #(.DIGITS(DIGITS)) bus ();

    led_scan_display #(
        .DIGITS     (DIGITS),
        .SCAN_DIV   (8),
        .DEAD_CYC   (2),
        .ACTIVE_LOW (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .o_seg         (o_seg),
        .o_dig_sel     (o_dig_sel),
        .o_frame_start (o_frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle write strobe issued at a sample point.
    task automatic do_load(input logic [5*DIGITS-1:0] data, input logic [DIGITS-1:0] mask);
        bus.digit_data = data;
        bus.blank_mask = mask;
        bus.load       = 1'b1;
        $display("load data=%h mask=%b", data, mask);
        step(1);
        bus.load = 1'b0;
    endtask

    // Bounded wait for the next frame-start sample.
    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!o_frame_start && n < 80);
        compared++;
        if (o_frame_start !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_frame_wait: o_frame_start=%b, required 1 within 80 cycles", tag, o_frame_start);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load = 1'b0;
        bus.digit_data = '0;
        bus.blank_mask = '0;
        step(2);
        compared++;
        if (o_seg !== 8'hFF || o_dig_sel !== 4'hF || bus.o_pending !== 1'b0 || o_frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: seg=%h sel=%h pend=%b fs=%b, required FF F 0 0",
                     o_seg, o_dig_sel, bus.o_pending, o_frame_start);
        end
        rst = 1'b0;
        step(1);
        compared++;
        if (o_frame_start !== 1'b1 || o_dig_sel !== 4'hF || o_seg !== 8'hFF) begin
            mismatched++;
            $display("FAIL reset_release: fs=%b sel=%h seg=%h, required 1 F FF", o_frame_start, o_dig_sel, o_seg);
        end
    endtask

    // Codes 3, dp+A, 7, 0 across one whole frame, every cycle.
    task automatic test_slot_scan();
        logic [7:0] exp_tab [4];
        logic [7:0] es;
        logic [3:0] ed;
        int s;
        int d;
        exp_tab = '{8'hB0, 8'h08, 8'hF8, ZERO_MS_SEG};
        do_load({5'h00, 5'h07, 5'h1A, 5'h03}, 4'b0000);
        wait_frame("slot_scan");
        for (int e = 0; e < 32; e++) begin
            s = e / 8;
            d = e % 8;
            if (d < 2) begin
                es = 8'hFF;
                ed = 4'hF;
            end else begin
                es = exp_tab[s];
                ed = ~(4'b0001 << s);
            end
            compared++;
            if (o_seg !== es || o_dig_sel !== ed || o_frame_start !== (e == 0)) begin
                mismatched++;
                $display("FAIL slot_scan e=%0d: seg=%h sel=%h fs=%b, required %h %h %b",
                         e, o_seg, o_dig_sel, o_frame_start, es, ed, (e == 0));
            end
            step(1);
        end
    endtask

    // Mid-frame write: old digits stay until the next frame.
    task automatic test_pending();
        step(10);
        do_load({5'h00, 5'h00, 5'h00, 5'h09}, 4'b0000);
        compared++;
        if (bus.o_pending !== 1'b1) begin
            mismatched++;
            $display("FAIL pending_set: pend=%b, required 1", bus.o_pending);
        end
        step(9);
        compared++;
        if (o_seg !== 8'hF8 || bus.o_pending !== 1'b1) begin
            mismatched++;
            $display("FAIL pending_old_data: seg=%h pend=%b, required F8 1", o_seg, bus.o_pending);
        end
        wait_frame("pending");
        compared++;
        if (bus.o_pending !== 1'b0) begin
            mismatched++;
            $display("FAIL pending_clear: pend=%b, required 0", bus.o_pending);
        end
        step(4);
        compared++;
        if (o_seg !== 8'h90 || o_dig_sel !== 4'hE) begin
            mismatched++;
            $display("FAIL pending_new_slot0: seg=%h sel=%h, required 90 E", o_seg, o_dig_sel);
        end
        step(16);
        compared++;
        if (o_seg !== ZERO_MS_SEG || o_dig_sel !== 4'hB) begin
            mismatched++;
            $display("FAIL pending_new_slot2: seg=%h sel=%h, required %h B", o_seg, o_dig_sel, ZERO_MS_SEG);
        end
        wait_frame("pending_end");
    endtask

    // Write on the boundary cycle goes straight to the display.
    task automatic test_back_to_back_boundary();
        step(30);
        do_load({5'h0F, 5'h02, 5'h05, 5'h1E}, 4'b0000);
        compared++;
        if (bus.o_pending !== 1'b0 || o_frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL boundary_load_pend: pend=%b fs=%b, required 0 0", bus.o_pending, o_frame_start);
        end
        step(1);
        compared++;
        if (o_frame_start !== 1'b1 || bus.o_pending !== 1'b0) begin
            mismatched++;
            $display("FAIL boundary_frame: fs=%b pend=%b, required 1 0", o_frame_start, bus.o_pending);
        end
        step(2);
        compared++;
        if (o_seg !== 8'h06 || o_dig_sel !== 4'hE || bus.o_pending !== 1'b0) begin
            mismatched++;
            $display("FAIL boundary_new_data: seg=%h sel=%h pend=%b, required 06 E 0",
                     o_seg, o_dig_sel, bus.o_pending);
        end
        wait_frame("boundary_end");
    endtask

    task automatic test_blank();
        logic [7:0] exp_seg [4];
        logic [3:0] exp_sel [4];
        exp_seg = '{8'h06, 8'h92, 8'hFF, 8'h8E};
        exp_sel = '{4'hE, 4'hD, 4'hB, 4'h7};
        do_load({5'h0F, 5'h02, 5'h05, 5'h1E}, 4'b0100);
        wait_frame("blank");
        step(3);
        for (int s = 0; s < 4; s++) begin
            compared++;
            if (o_seg !== exp_seg[s] || o_dig_sel !== exp_sel[s]) begin
                mismatched++;
                $display("FAIL blank_slot%0d: seg=%h sel=%h, required %h %h",
                         s, o_seg, o_dig_sel, exp_seg[s], exp_sel[s]);
            end
            step(8);
        end
        wait_frame("blank_end");
    endtask

    task automatic test_zero_suppress();
        logic [7:0] exp_seg [4];
        logic [3:0] exp_sel [4];
        exp_seg = '{8'hC0, 8'h92, ZERO_MS_SEG, ZERO_MS_SEG};
        exp_sel = '{4'hE, 4'hD, 4'hB, 4'h7};
        do_load({5'h00, 5'h00, 5'h05, 5'h00}, 4'b0000);
        wait_frame("zero");
        step(4);
        for (int s = 0; s < 4; s++) begin
            compared++;
            if (o_seg !== exp_seg[s] || o_dig_sel !== exp_sel[s]) begin
                mismatched++;
                $display("FAIL zero_slot%0d: seg=%h sel=%h, required %h %h",
                         s, o_seg, o_dig_sel, exp_seg[s], exp_sel[s]);
            end
            step(8);
        end
        wait_frame("zero_end");
    endtask

    // Reset in the middle of a lit slot blanks outputs without a clock edge.
    task automatic test_async_reset();
        step(13);
        rst = 1'b1;
        #1;
        compared++;
        if (o_seg !== 8'hFF || o_dig_sel !== 4'hF || bus.o_pending !== 1'b0 || o_frame_start !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: seg=%h sel=%h pend=%b fs=%b, required FF F 0 0",
                     o_seg, o_dig_sel, bus.o_pending, o_frame_start);
        end
        step(2);
        rst = 1'b0;
        step(1);
        compared++;
        if (o_frame_start !== 1'b1 || o_dig_sel !== 4'hF) begin
            mismatched++;
            $display("FAIL async_restart: fs=%b sel=%h, required 1 F", o_frame_start, o_dig_sel);
        end
        step(2);
        compared++;
        if (o_seg !== 8'hC0 || o_dig_sel !== 4'hE) begin
            mismatched++;
            $display("FAIL async_cleared_data: seg=%h sel=%h, required C0 E", o_seg, o_dig_sel);
        end
    endtask

    initial begin
        test_reset();
        test_slot_scan();
        test_pending();
        test_back_to_back_boundary();
        test_blank();
        test_zero_suppress();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
